// File: rtl/countdown_timer.sv
// countdown_timer: BCD mm:ss countdown with load, start/stop/pause and
// expiry reporting. All outputs come straight from flops.
module countdown_timer #(
    parameter int unsigned MIN_TENS_MAX = 5
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        CE,
    input  logic        IMPULSE,
    input  logic        LOAD,
    input  logic        START,
    input  logic        STOP,
    input  logic [15:0] PRESET,
    output logic [15:0] COUNT,
    output logic        RUNNING,
    output logic        EXPIRED,
    output logic        TIMEOUT
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSE   = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

    state_t      state;
    state_t      state_n;
    logic [15:0] count;
    logic [15:0] count_n;
    logic        running;
    logic        expired;
    logic        timeout;
    logic        timeout_n;

    // Clamp each preset digit to its legal maximum.
    function automatic logic [15:0] clamp_preset(input logic [15:0] p);
        logic [3:0] mt, mo, st, so;
        mt = (p[15:12] > MT_MAX) ? MT_MAX : p[15:12];
        mo = (p[11:8]  > 4'd9)   ? 4'd9   : p[11:8];
        st = (p[7:4]   > 4'd5)   ? 4'd5   : p[7:4];
        so = (p[3:0]   > 4'd9)   ? 4'd9   : p[3:0];
        return {mt, mo, st, so};
    endfunction

    // One-second BCD decrement with borrow cascade; caller guarantees v != 0.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = v;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    // State, count and registered status flags.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state   <= S_IDLE;
            count   <= '0;
            running <= 1'b0;
            expired <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            running <= (state_n == S_RUN);
            expired <= (state_n == S_EXPIRED);
            timeout <= timeout_n;
        end
    end

    // Next-state and next-count; LOAD overrides everything else.
    always_comb begin
        state_n   = state;
        count_n   = count;
        timeout_n = 1'b0;
        if (LOAD) begin
            state_n = S_IDLE;
            count_n = clamp_preset(PRESET);
        end else begin
            case (state)
                S_IDLE, S_PAUSE: begin
                    if (START && !STOP && (count != 16'h0000)) begin
                        state_n = S_RUN;
                    end
                end
                S_RUN: begin
                    if (STOP) begin
                        state_n = S_PAUSE;
                    end else if (CE && IMPULSE) begin
                        if (count <= 16'h0001) begin
                            count_n   = '0;
                            state_n   = S_EXPIRED;
                            timeout_n = 1'b1;
                        end else begin
                            count_n = bcd_dec(count);
                        end
                    end
                end
                S_EXPIRED: begin
                    count_n = '0;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    assign COUNT   = count;
    assign RUNNING = running;
    assign EXPIRED = expired;
    assign TIMEOUT = timeout;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter MIN_TENS_MAX, default 5, giving the highest minutes-tens digit value (legal range 1..9).
REQ-002 The block SHALL have port CLK, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port CLR, input, 1 bit: reset; one clock, reset is asynchronous and active-low.
REQ-004 The block SHALL have port CE, input, 1 bit: clock enable; when 0, IMPULSE is ignored.
REQ-005 The block SHALL have port IMPULSE, input, 1 bit: one-cycle 1 Hz time-base tick.
REQ-006 The block SHALL have port LOAD, input, 1 bit: synchronous load of PRESET.
REQ-007 The block SHALL have port START, input, 1 bit: run request.
REQ-008 The block SHALL have port STOP, input, 1 bit: pause request.
REQ-009 The block SHALL have port PRESET, input, 16 bits: BCD preset {min tens, min ones, sec tens, sec ones}, 4 bits each.
REQ-010 The block SHALL have port COUNT, output, 16 bits: registered BCD remaining time, same digit order as PRESET.
REQ-011 The block SHALL have port RUNNING, output, 1 bit: high while state is RUN.
REQ-012 The block SHALL have port EXPIRED, output, 1 bit: high while state is EXPIRED.
REQ-013 The block SHALL have port TIMEOUT, output, 1 bit: single-cycle expiry pulse.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE, EXPIRED.
REQ-015 LOAD=1 SHALL, from any state, set COUNT to PRESET and the state to IDLE at the next edge, overriding START, STOP and IMPULSE.
REQ-016 On load, any preset digit above its maximum (sec ones 9, sec tens 5, min ones 9, min tens MIN_TENS_MAX) SHALL be clamped to that maximum.
REQ-017 START=1 with STOP=0 SHALL move IDLE or PAUSE to RUN if COUNT is nonzero; with COUNT=00:00 the state SHALL remain unchanged.
REQ-018 STOP=1 SHALL move RUN to PAUSE; STOP SHALL win when START and STOP are asserted together.
REQ-019 In RUN, each edge with CE=1 and IMPULSE=1 SHALL decrement COUNT by one second; otherwise COUNT SHALL hold.
REQ-020 Decrement SHALL borrow as a cascade: sec ones 0->9 borrows from sec tens, sec tens 0->5 borrows from min ones, min ones 0->9 borrows from min tens.
REQ-021 A decrement from 00:01 SHALL set COUNT to 00:00 and the state to EXPIRED on the same edge, and COUNT SHALL never wrap below 00:00.
REQ-022 TIMEOUT SHALL be high for exactly the one cycle following the edge that entered EXPIRED, and low otherwise.
REQ-023 In EXPIRED, COUNT SHALL hold 00:00, START, STOP and IMPULSE SHALL be ignored, and only LOAD or reset SHALL exit.
REQ-024 An IMPULSE arriving on the same edge as a RUN->PAUSE transition SHALL NOT decrement COUNT.
REQ-025 An IMPULSE arriving on the same edge as an IDLE/PAUSE->RUN transition SHALL NOT decrement COUNT, so the first decrement is on the next qualifying tick.
REQ-026 In IDLE and PAUSE, COUNT SHALL hold regardless of IMPULSE.
REQ-027 All outputs SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-028 While CLR=0, the state SHALL be IDLE, COUNT SHALL be 16'h0000, and RUNNING, EXPIRED and TIMEOUT SHALL be 0, asynchronously and independent of CLK.
REQ-029 Reset asserted mid-RUN or mid-EXPIRED SHALL abort immediately, with no TIMEOUT pulse generated.
REQ-030 After CLR deasserts, the block SHALL respond to inputs from the first following CLK edge.

Verification
REQ-031 Bench: reset, LOAD with PRESET=16'h0103, START, then 3 IMPULSE ticks -> COUNT 01:02, 01:01, 01:00, RUNNING=1 throughout.
REQ-032 Bench: from 01:00, one tick -> 00:59; continue to 00:01, then one tick -> COUNT=00:00, EXPIRED=1, one-cycle TIMEOUT, RUNNING=0; further START and IMPULSE leave it unchanged.
REQ-033 Bench: during RUN at 00:30, STOP with simultaneous IMPULSE -> PAUSE at 00:30; 5 ticks -> still 00:30; START+STOP together -> still PAUSE; START -> RUN.
REQ-034 Bench: CE=0 in RUN with 4 ticks -> COUNT unchanged; LOAD PRESET=16'h7A6F -> COUNT=16'h5959 (MIN_TENS_MAX=5), state IDLE.
REQ-035 Bench: LOAD 00:00 then START -> stays IDLE with no TIMEOUT; CLR=0 mid-RUN between clock edges -> outputs zero immediately, no TIMEOUT pulse.
